// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types and constants for the valid/ready link
package rv_pkg;

    localparam int DATA_W_DEF = 64;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/rv_fifo.sv
// rtl/rv_fifo.sv - synchronous DEPTH x DATA_W FIFO with flush
module rv_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    // Flush wins over both push and pop at the same edge.
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rv_transmitter.sv
// rtl/rv_transmitter.sv - FIFO-backed source end of the valid/ready link
module rv_transmitter
    import rv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              flush,
    output logic              valid,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready,
    output logic              tx_done,
    output logic [CNT_W-1:0]  tx_count
);

    tx_state_t         r_state;
    tx_state_t         w_next_state;
    logic [DATA_W-1:0] r_data;
    logic              r_tx_done;
    logic [CNT_W-1:0]  r_tx_count;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_pop;
    logic              w_handshake;

    assign push_ready = !w_full && !flush;
    assign valid      = (r_state == SEND);
    assign data_out   = r_data;
    assign tx_done    = r_tx_done;
    assign tx_count   = r_tx_count;

    rv_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (push_valid && push_ready),
        .i_push_data (push_data),
        .i_pop       (w_pop),
        .i_flush     (flush),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !flush) begin
                    w_pop        = 1'b1;
                    w_next_state = SEND;
                end
            end
            SEND: begin
                // Without ready the offered word is held untouched.
                if (ready) begin
                    w_handshake = 1'b1;
                    if (!w_empty && !flush) begin
                        w_pop = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_data     <= '0;
            r_tx_done  <= 1'b0;
            r_tx_count <= '0;
        end else begin
            r_state   <= w_next_state;
            r_tx_done <= w_handshake;
            if (w_pop) begin
                r_data <= w_head;
            end
            if (w_handshake) begin
                r_tx_count <= r_tx_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_transmitter.sv
// tb/tb_rv_transmitter.sv - directed and random checks against a queue model
module tb_rv_transmitter;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          flush;
    logic          valid;
    logic [DW-1:0] data_out;
    logic          ready;
    logic          tx_done;
    logic [CW-1:0] tx_count;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic          m_done  = 1'b0;
    logic [CW-1:0] m_cnt   = '0;

    rv_transmitter #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .flush      (flush),
        .valid      (valid),
        .data_out   (data_out),
        .ready      (ready),
        .tx_done    (tx_done),
        .tx_count   (tx_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the reference model, compare outputs.
    task automatic tick(input logic pv, input logic [DW-1:0] pd, input logic fl,
                        input logic rd, input logic rs);
        logic hs;
        logic room;
        push_valid = pv;
        push_data  = pd;
        flush      = fl;
        ready      = rd;
        reset      = rs;
        #1;
        if (!rs) chk("push_ready", push_ready, (q.size() < DEPTH) && !fl);
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_done  = 1'b0;
            m_cnt   = '0;
        end else begin
            hs     = m_valid && rd;
            room   = q.size() < DEPTH;
            m_done = hs;
            if (hs) m_cnt = m_cnt + 1'b1;
            if (!m_valid || hs) begin
                if (!fl && q.size() > 0) begin
                    m_data  = q.pop_front();
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (fl) q.delete();
            if (pv && room && !fl) q.push_back(pd);
        end
        #1;
        chk("valid", valid, m_valid);
        chk("tx_done", tx_done, m_done);
        chk("tx_count", tx_count, m_cnt);
        if (m_valid || rs) chk("data_out", data_out, m_data);
    endtask

    initial begin
        push_valid = 1'b0;
        push_data  = '0;
        flush      = 1'b0;
        ready      = 1'b0;
        reset      = 1'b1;

        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        chk("reset_valid", valid, 1'b0);
        chk("reset_count", tx_count, 0);

        // Single word with three stall cycles.
        tick(1, 64'hDEADBEEFCAFEBABE, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("single_valid_rise", valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 0);
            chk("single_stall_data", data_out, 64'hDEADBEEFCAFEBABE);
        end
        tick(0, 0, 0, 1, 0);
        chk("single_done", tx_done, 1'b1);
        tick(0, 0, 0, 0, 0);
        chk("single_done_once", tx_done, 1'b0);
        chk("single_count", tx_count, 1);

        // Streaming with ready held high.
        for (int i = 1; i <= 4; i++) tick(1, DW'(i), 0, 1, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 0);
        chk("stream_count", tx_count, 5);
        chk("stream_idle", valid, 1'b0);

        // Fill the FIFO behind a stalled output stage.
        for (int i = 0; i < 6; i++) tick(1, 64'h100 + DW'(i), 0, 0, 0);
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 0);
        chk("full_count", tx_count, 10);

        // Flush with a word held in the output stage.
        tick(1, 64'hA, 0, 0, 0);
        tick(1, 64'hB, 0, 0, 0);
        tick(1, 64'hC, 0, 0, 0);
        chk("flush_hold", data_out, 64'hA);
        tick(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 0);
        chk("flush_count", tx_count, 11);

        // Early ready with nothing to send.
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 0);
        tick(1, 64'h55, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
        chk("early_count", tx_count, 12);

        // Reset while a word is offered.
        tick(1, 64'h77, 0, 0, 0);
        tick(1, 64'h78, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        chk("midreset_valid", valid, 1'b0);
        chk("midreset_count", tx_count, 0);
        tick(1, 64'h99, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
        chk("after_reset_count", tx_count, 1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            tick(($urandom_range(0, 2) != 0), {$urandom, $urandom},
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
